// File: rtl/alu_ctrl_seq.sv
// Registered ALU controller: decodes aluop/funct into ALU control, shamt/jump selects
// and an illegal flag, and holds the pipeline with stall_o while a multiply completes.
module alu_ctrl_seq #(
  parameter int FUNCT_W    = 6,
  parameter int ALUOP_W    = 3,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               flush_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  output logic [CTRL_W-1:0]  alu_ctrl_o,
  output logic               shamt_sel_o,
  output logic               jump_sel_o,
  output logic               illegal_o,
  output logic               valid_o,
  output logic               stall_o,
  output logic               dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 2);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic                shamt_sel_q, shamt_sel_d;
  logic                jump_sel_q, jump_sel_d;
  logic                illegal_q, illegal_d;
  logic                valid_q, valid_d;

  logic [CTRL_W-1:0]   dec_ctrl;
  logic                dec_shamt, dec_jump, dec_illegal, dec_mul;
  logic                funct_hi_nz, aluop_hi_nz;
  logic                accept;

  // Handshake: an instruction is taken on a rising edge when valid_i & ready_o & ~flush_i;
  // ready_o is high only in IDLE, and valid_o pulses for one cycle once an op's result is final.
  assign ready_o     = (state_q == IDLE);
  assign stall_o     = (state_q == BUSY);
  assign accept      = valid_i & ready_o & ~flush_i;
  assign dbg_state_o = state_q;

  assign funct_hi_nz = (funct_i >> 6) != '0;
  assign aluop_hi_nz = (aluop_i >> 3) != '0;

  always_comb begin
    dec_ctrl    = CTRL_W'(4'b1111);
    dec_shamt   = 1'b0;
    dec_jump    = 1'b0;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    if (aluop_hi_nz) begin
      dec_illegal = 1'b1;
    end else begin
      case (aluop_i[2:0])
        3'd0: begin
          if (funct_hi_nz) begin
            dec_illegal = 1'b1;
          end else begin
            case (funct_i[5:0])
              6'd3:  begin dec_ctrl = CTRL_W'(4'b1000); dec_shamt = 1'b1; end
              6'd7:  dec_ctrl = CTRL_W'(4'b1001);
              6'd24: begin dec_ctrl = CTRL_W'(4'b0101); dec_mul = 1'b1; end
              6'd32: dec_ctrl = CTRL_W'(4'b0010);
              6'd34: dec_ctrl = CTRL_W'(4'b0110);
              6'd36: dec_ctrl = CTRL_W'(4'b0000);
              6'd37: dec_ctrl = CTRL_W'(4'b0001);
              6'd42: dec_ctrl = CTRL_W'(4'b0100);
              6'd8:  begin dec_ctrl = CTRL_W'(4'b0000); dec_jump = 1'b1; end
              default: dec_illegal = 1'b1;
            endcase
          end
        end
        3'd1: dec_ctrl = CTRL_W'(4'b0111);
        3'd2: dec_ctrl = CTRL_W'(4'b1010);
        3'd3: dec_ctrl = CTRL_W'(4'b0010);
        3'd4: dec_ctrl = CTRL_W'(4'b0011);
        3'd5: dec_ctrl = CTRL_W'(4'b0001);
        3'd6: dec_ctrl = CTRL_W'(4'b1011);
        default: dec_ctrl = CTRL_W'(4'b1100);
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_ctrl_d  = alu_ctrl_q;
    shamt_sel_d = shamt_sel_q;
    jump_sel_d  = jump_sel_q;
    illegal_d   = illegal_q;
    valid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_ctrl_d  = dec_ctrl;
          shamt_sel_d = dec_shamt;
          jump_sel_d  = dec_jump;
          illegal_d   = dec_illegal;
          if (dec_mul) begin
            state_d = BUSY;
            cnt_d   = '0;
          end else begin
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        // Flush takes priority over completion, so a flushed multiply never reports valid.
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_ctrl_q  <= '0;
      shamt_sel_q <= 1'b0;
      jump_sel_q  <= 1'b0;
      illegal_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_ctrl_q  <= alu_ctrl_d;
      shamt_sel_q <= shamt_sel_d;
      jump_sel_q  <= jump_sel_d;
      illegal_q   <= illegal_d;
      valid_q     <= valid_d;
    end
  end

  assign alu_ctrl_o  = alu_ctrl_q;
  assign shamt_sel_o = shamt_sel_q;
  assign jump_sel_o  = jump_sel_q;
  assign illegal_o   = illegal_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: reset, decode tables, back-to-back accepts,
// multiply stall sequencing and flush behaviour, with hand-computed expectations.
module tb_alu_ctrl_seq;

  localparam int FUNCT_W    = 6;
  localparam int ALUOP_W    = 3;
  localparam int CTRL_W     = 4;
  localparam int MUL_CYCLES = 4;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               valid_i;
  logic               ready_o;
  logic               flush_i;
  logic [FUNCT_W-1:0] funct_i;
  logic [ALUOP_W-1:0] aluop_i;
  logic [CTRL_W-1:0]  alu_ctrl_o;
  logic               shamt_sel_o;
  logic               jump_sel_o;
  logic               illegal_o;
  logic               valid_o;
  logic               stall_o;
  logic               dbg_state_o;

  int errors = 0;
  int checks = 0;

  alu_ctrl_seq #(
    .FUNCT_W(FUNCT_W), .ALUOP_W(ALUOP_W), .CTRL_W(CTRL_W), .MUL_CYCLES(MUL_CYCLES)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .funct_i(funct_i), .aluop_i(aluop_i),
    .alu_ctrl_o(alu_ctrl_o), .shamt_sel_o(shamt_sel_o), .jump_sel_o(jump_sel_o),
    .illegal_o(illegal_o), .valid_o(valid_o), .stall_o(stall_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock/reset block
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [ALUOP_W-1:0] op, input logic [FUNCT_W-1:0] f);
    valid_i = v;
    aluop_i = op;
    funct_i = f;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; drive(1'b0, '0, '0);
    tick(); tick();
    checks++;
    if ({alu_ctrl_o, shamt_sel_o, jump_sel_o, illegal_o, valid_o, stall_o, ready_o} !== 10'b0000_00000_1) begin
      errors++;
      $display("FAIL reset_state got=%b required=%b",
               {alu_ctrl_o, shamt_sel_o, jump_sel_o, illegal_o, valid_o, stall_o, ready_o}, 10'b0000_00000_1);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_mul();
    drive(1'b1, 3'd0, 6'd24);
    tick();
    drive(1'b0, 3'd0, 6'd0);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL mid_mul_stall_before_reset got=%b required=1", stall_o);
    end
    tick();
    rst_i = 1'b1;
    #1;
    checks++;
    if ({alu_ctrl_o, shamt_sel_o, jump_sel_o, illegal_o, valid_o, stall_o, ready_o, dbg_state_o} !== 11'b0000_00000_10) begin
      errors++;
      $display("FAIL async_reset_mid_mul got=%b required=%b",
               {alu_ctrl_o, shamt_sel_o, jump_sel_o, illegal_o, valid_o, stall_o, ready_o, dbg_state_o}, 11'b0000_00000_10);
    end
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] f_tab [3] = '{6'd32, 6'd34, 6'd42};
    logic [3:0] c_tab [3] = '{4'b0010, 4'b0110, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, f_tab[i]);
      tick();
      checks++;
      if (valid_o !== 1'b1 || alu_ctrl_o !== c_tab[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d] got valid=%b ctrl=%b required valid=1 ctrl=%b", i, valid_o, alu_ctrl_o, c_tab[i]);
      end
    end
    drive(1'b0, 3'd0, 6'd9);
    tick();
    checks++;
    if (valid_o !== 1'b0 || alu_ctrl_o !== 4'b0100 || illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got valid=%b ctrl=%b ill=%b required valid=0 ctrl=0100 ill=0", valid_o, alu_ctrl_o, illegal_o);
    end
  endtask

  task automatic test_mul();
    drive(1'b1, 3'd0, 6'd24);
    tick();
    drive(1'b1, 3'd0, 6'd32);  // presented while busy; must be ignored
    for (int i = 0; i < MUL_CYCLES - 1; i++) begin
      checks++;
      if (stall_o !== 1'b1 || ready_o !== 1'b0 || valid_o !== 1'b0 || alu_ctrl_o !== 4'b0101) begin
        errors++;
        $display("FAIL mul_busy[%0d] got stall=%b ready=%b valid=%b ctrl=%b required 1 0 0 0101",
                 i, stall_o, ready_o, valid_o, alu_ctrl_o);
      end
      tick();
    end
    checks++;
    if (stall_o !== 1'b0 || ready_o !== 1'b1 || valid_o !== 1'b1 || alu_ctrl_o !== 4'b0101) begin
      errors++;
      $display("FAIL mul_done got stall=%b ready=%b valid=%b ctrl=%b required 0 1 1 0101",
               stall_o, ready_o, valid_o, alu_ctrl_o);
    end
    drive(1'b0, 3'd0, 6'd0);
    tick();
    checks++;
    if (valid_o !== 1'b0 || alu_ctrl_o !== 4'b0101) begin
      errors++; $display("FAIL mul_pulse_width got valid=%b ctrl=%b required valid=0 ctrl=0101", valid_o, alu_ctrl_o);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 3'd0, 6'd24);
    tick();
    drive(1'b0, 3'd0, 6'd0);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (dbg_state_o !== 1'b0 || ready_o !== 1'b1 || stall_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy got state=%b ready=%b stall=%b valid=%b required 0 1 0 0",
               dbg_state_o, ready_o, stall_o, valid_o);
    end
    for (int i = 0; i < MUL_CYCLES; i++) begin
      tick();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++; $display("FAIL flush_no_valid[%0d] got=%b required=0", i, valid_o);
      end
    end
    drive(1'b1, 3'd0, 6'd32);
    tick();
    checks++;
    if (valid_o !== 1'b1 || alu_ctrl_o !== 4'b0010) begin
      errors++; $display("FAIL add_after_flush got valid=%b ctrl=%b required 1 0010", valid_o, alu_ctrl_o);
    end
    drive(1'b1, 3'd0, 6'd34);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || alu_ctrl_o !== 4'b0010 || ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_idle got valid=%b ctrl=%b ready=%b required 0 0010 1", valid_o, alu_ctrl_o, ready_o);
    end
    drive(1'b1, 3'd0, 6'd24);
    tick();
    drive(1'b0, 3'd0, 6'd0);
    tick(); tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || stall_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_final_edge got valid=%b stall=%b ready=%b required 0 0 1", valid_o, stall_o, ready_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_final_late_valid got=%b required=0", valid_o);
    end
  endtask

  task automatic test_funct_decode();
    // expected {ctrl, shamt, jump, illegal}
    logic [5:0] f_tab [10] = '{6'd3, 6'd7, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd8, 6'd9, 6'd63};
    logic [6:0] e_tab [10] = '{7'b1000_100, 7'b1001_000, 7'b0010_000, 7'b0110_000, 7'b0000_000,
                               7'b0001_000, 7'b0100_000, 7'b0000_010, 7'b1111_001, 7'b1111_001};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd0, f_tab[i]);
      tick();
      checks++;
      if ({alu_ctrl_o, shamt_sel_o, jump_sel_o, illegal_o} !== e_tab[i] || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL funct_decode[%0d] funct=%0d got=%b valid=%b required=%b valid=1",
                 i, f_tab[i], {alu_ctrl_o, shamt_sel_o, jump_sel_o, illegal_o}, valid_o, e_tab[i]);
      end
    end
    drive(1'b0, 3'd0, 6'd0);
    tick();
  endtask

  task automatic test_aluop_sweep();
    logic [3:0] c_tab [7] = '{4'b0111, 4'b1010, 4'b0010, 4'b0011, 4'b0001, 4'b1011, 4'b1100};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ALUOP_W'(i + 1), FUNCT_W'($urandom_range(0, 63)));
      tick();
      checks++;
      if (alu_ctrl_o !== c_tab[i] || illegal_o !== 1'b0 || shamt_sel_o !== 1'b0 ||
          jump_sel_o !== 1'b0 || valid_o !== 1'b1 || stall_o !== 1'b0) begin
        errors++;
        $display("FAIL aluop_sweep[%0d] got ctrl=%b ill=%b sh=%b jp=%b valid=%b stall=%b required ctrl=%b ill=0 sh=0 jp=0 valid=1 stall=0",
                 i + 1, alu_ctrl_o, illegal_o, shamt_sel_o, jump_sel_o, valid_o, stall_o, c_tab[i]);
      end
    end
    drive(1'b0, 3'd0, 6'd0);
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_mul();
    test_back_to_back();
    test_mul();
    test_flush();
    test_funct_decode();
    test_aluop_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
